// File: rtl/hamming_pkg.sv
// hamming_pkg: Hamming(7,4) types and decode helpers shared by the serial receiver and the encoder.
package hamming_pkg;
  localparam int CW_W = 7;
  localparam int DATA_W = 4;
  typedef logic [CW_W-1:0] codeword_t;
  typedef logic [DATA_W-1:0] nibble_t;
  typedef logic [2:0] syndrome_t;
  typedef enum logic {IDLE, SHIFT} rx_state_t;
  function automatic syndrome_t hamming_syndrome(input codeword_t cw);
    return {cw[3] ^ cw[4] ^ cw[5] ^ cw[6], cw[1] ^ cw[2] ^ cw[5] ^ cw[6], cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
  endfunction
  // The syndrome is the 1-based position of the flipped bit.
  function automatic nibble_t hamming_correct(input codeword_t cw);
    syndrome_t s;
    codeword_t c;
    s = hamming_syndrome(cw);
    c = (s == 3'd0) ? cw : cw ^ (codeword_t'(1) << (s - 3'd1));
    return {c[6], c[5], c[4], c[2]};
  endfunction
endpackage

// File: rtl/hamming_rx_fifo.sv
// hamming_rx_fifo: 2-entry valid/ready queue; the caller only pushes when there is room.
module hamming_rx_fifo #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   cnt;
  logic         do_pop;
  assign full = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign head = mem[rd_ptr];
  assign do_pop = pop && !empty;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/hamming_serial_rx.sv
// hamming_serial_rx: deframes a bit-serial Hamming(7,4) stream, corrects single-bit errors,
// queues nibbles behind a valid/ready handshake and keeps saturating statistics.
module hamming_serial_rx
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_valid,
  input  logic             ser_bit,
  input  logic             ser_sof,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [3:0]       data_out,
  output logic             err_corrected,
  output logic             overrun,
  output logic             sync_err,
  input  logic             clear_cnt,
  output logic [CNT_W-1:0] cnt_frames,
  output logic [CNT_W-1:0] cnt_corrected
);
  rx_state_t state, state_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  codeword_t sr, sr_d, full_cw;
  logic cw_done, sync_d;
  logic pend_v, pend_err;
  nibble_t pend_nib;
  logic fifo_full, fifo_empty, pop, accept;
  logic [4:0] head;
  assign full_cw = {ser_bit, sr[5:0]};
  always_comb begin
    state_d = state;
    bit_cnt_d = bit_cnt;
    sr_d = sr;
    cw_done = 1'b0;
    sync_d = 1'b0;
    if (ser_valid && ser_sof) begin
      sync_d = state == SHIFT;
      state_d = SHIFT;
      bit_cnt_d = 3'd1;
      sr_d = codeword_t'(ser_bit);
    end else if (ser_valid && state == SHIFT) begin
      sr_d[bit_cnt] = ser_bit;
      cw_done = bit_cnt == 3'd6;
      state_d = cw_done ? IDLE : SHIFT;
      bit_cnt_d = cw_done ? 3'd0 : bit_cnt + 3'd1;
    end
  end
  // Decoded word waits one register stage before entering the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= 3'd0;
      sr <= '0;
      pend_v <= 1'b0;
      pend_nib <= '0;
      pend_err <= 1'b0;
      sync_err <= 1'b0;
      overrun <= 1'b0;
      cnt_frames <= '0;
      cnt_corrected <= '0;
    end else begin
      state <= state_d;
      bit_cnt <= bit_cnt_d;
      sr <= sr_d;
      pend_v <= cw_done;
      pend_nib <= hamming_correct(full_cw);
      pend_err <= |hamming_syndrome(full_cw);
      sync_err <= sync_d;
      overrun <= pend_v && !accept;
      cnt_frames <= clear_cnt ? '0 : (accept && !(&cnt_frames)) ? cnt_frames + 1'b1 : cnt_frames;
      cnt_corrected <= clear_cnt ? '0 : (accept && pend_err && !(&cnt_corrected)) ? cnt_corrected + 1'b1 : cnt_corrected;
    end
  end
  assign pop = data_valid && data_ready;
  assign accept = pend_v && (!fifo_full || pop);
  assign data_valid = !fifo_empty;
  assign data_out = head[3:0];
  assign err_corrected = head[4];
  hamming_rx_fifo #(.W(5)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(accept),
    .push_data({pend_err, pend_nib}),
    .pop(pop),
    .head(head),
    .full(fifo_full),
    .empty(fifo_empty)
  );
endmodule

// File: tb/tb_hamming_serial_rx.sv
// tb_hamming_serial_rx: directed stimulus; a nearest-codeword model feeds a scoreboard checked on every handshake.
module tb_hamming_serial_rx;
  logic clk = 1'b0;
  logic rst_n, ser_valid, ser_bit, ser_sof, data_ready, clear_cnt;
  logic data_valid, err_corrected, overrun, sync_err;
  logic [3:0] data_out;
  logic [1:0] cnt_frames, cnt_corrected;
  int n_cmp = 0, n_bad = 0, n_ovr = 0, n_sync = 0;
  int mdl_frames = 0, mdl_corr = 0;
  logic [4:0] exp_q[$];
  logic prev_v = 1'b0, prev_r = 1'b0;
  logic [4:0] prev_h = '0;
  logic [6:0] w [3];
  always #5 clk = ~clk;
  hamming_serial_rx #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .ser_valid(ser_valid), .ser_bit(ser_bit), .ser_sof(ser_sof),
    .data_valid(data_valid), .data_ready(data_ready), .data_out(data_out),
    .err_corrected(err_corrected), .overrun(overrun), .sync_err(sync_err),
    .clear_cnt(clear_cnt), .cnt_frames(cnt_frames), .cnt_corrected(cnt_corrected)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [6:0] enc(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction
  // Decode by searching for the data nibble whose codeword lies within distance 1.
  function automatic logic [4:0] dec(input logic [6:0] rx);
    for (int d = 0; d < 16; d++) begin
      logic [3:0] dn;
      logic [6:0] e;
      dn = d[3:0];
      e = enc(dn);
      if ($countones(e ^ rx) <= 1) return {e != rx, dn};
    end
    return 5'h1f;
  endfunction
  task automatic model_accept(input logic [6:0] rx);
    logic [4:0] item;
    item = dec(rx);
    exp_q.push_back(item);
    mdl_frames = (mdl_frames == 3) ? 3 : mdl_frames + 1;
    if (item[4]) mdl_corr = (mdl_corr == 3) ? 3 : mdl_corr + 1;
  endtask
  task automatic send_bits(input logic [6:0] cw, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      ser_valid = 1'b1;
      ser_bit = cw[i];
      ser_sof = (i == 0);
      @(posedge clk);
      #1;
      ser_valid = 1'b0;
      ser_sof = 1'b0;
      if (i < nbits - 1) repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
    check("drain_left", exp_q.size(), 0);
  endtask
  task automatic clear_counters();
    clear_cnt = 1'b1;
    idle(1);
    clear_cnt = 1'b0;
    mdl_frames = 0;
    mdl_corr = 0;
    check("clr_frames", cnt_frames, 0);
    check("clr_corr", cnt_corrected, 0);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_v && !prev_r && data_valid) check("hold", {err_corrected, data_out}, prev_h);
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pop: got %0h expected none", {err_corrected, data_out});
        end else check("head", {err_corrected, data_out}, exp_q.pop_front());
      end
      if (overrun) n_ovr++;
      if (sync_err) n_sync++;
    end
    prev_v = rst_n && data_valid;
    prev_r = data_ready;
    prev_h = {err_corrected, data_out};
  end
  initial begin
    rst_n = 1'b0;
    ser_valid = 1'b0;
    ser_bit = 1'b0;
    ser_sof = 1'b0;
    data_ready = 1'b1;
    clear_cnt = 1'b0;
    check("pin_enc", enc(4'b1010), 7'b1010010);
    check("pin_dec_err", dec(7'b1011010), 5'b11010);
    check("pin_dec_ok", dec(7'b1010010), 5'b01010);
    #12;
    check("rst_valid", data_valid, 0);
    check("rst_data", {err_corrected, data_out}, 0);
    check("rst_pulses", {overrun, sync_err}, 0);
    check("rst_cnt", {cnt_frames, cnt_corrected}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    model_accept(7'b1010010);
    send_bits(7'b1010010, 7, 0);
    check("clean_lat", data_valid, 0);
    idle(1);
    check("clean_valid", data_valid, 1);
    check("clean_data", data_out, 4'b1010);
    check("clean_err", err_corrected, 0);
    check("clean_frames", cnt_frames, 1);
    idle(1);
    check("clean_1cyc", data_valid, 0);
    model_accept(7'b1011010);
    send_bits(7'b1011010, 7, 0);
    idle(2);
    check("err_corr", cnt_corrected, 1);
    check("err_frames", cnt_frames, mdl_frames);
    clear_counters();
    w[0] = enc(4'b0110);
    w[1] = enc(4'b1001);
    w[2] = enc(4'b1111);
    data_ready = 1'b0;
    n_ovr = 0;
    model_accept(w[0]);
    model_accept(w[1]);
    for (int i = 0; i < 3; i++) send_bits(w[i], 7, 0);
    idle(3);
    check("bp_overrun", n_ovr, 1);
    check("bp_frames", cnt_frames, 2);
    check("bp_valid", data_valid, 1);
    check("bp_head", data_out, 4'b0110);
    data_ready = 1'b1;
    drain();
    idle(1);
    check("bp_empty", data_valid, 0);
    clear_counters();
    n_sync = 0;
    send_bits(7'b1111111, 3, 0);
    model_accept(7'b1010010);
    send_bits(7'b1010010, 7, 0);
    idle(3);
    check("resync_pulse", n_sync, 1);
    check("resync_frames", cnt_frames, 1);
    drain();
    model_accept(7'b1010010);
    send_bits(7'b1010010, 7, 2);
    idle(3);
    check("gap_frames", cnt_frames, mdl_frames);
    drain();
    data_ready = 1'b0;
    send_bits(7'b1010010, 7, 0);
    idle(1);
    send_bits(7'b0101101, 4, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", data_valid, 0);
    check("rst_mid_data", {err_corrected, data_out}, 0);
    check("rst_mid_cnt", {cnt_frames, cnt_corrected}, 0);
    mdl_frames = 0;
    mdl_corr = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    data_ready = 1'b1;
    model_accept(7'b1010010);
    send_bits(7'b1010010, 7, 0);
    drain();
    check("post_rst_frames", cnt_frames, 1);
    clear_counters();
    for (int k = 0; k < 5; k++) begin
      logic [6:0] rx;
      logic [3:0] d;
      d = 4'(k * 3 + 1);
      rx = enc(d) ^ (7'b1 << k);
      model_accept(rx);
      send_bits(rx, 7, 0);
    end
    idle(3);
    check("sat_corr", cnt_corrected, 3);
    check("sat_frames", cnt_frames, mdl_frames);
    check("sat_model", cnt_corrected, mdl_corr);
    drain();
    clear_counters();
    model_accept(7'b1010010);
    send_bits(7'b1010010, 7, 0);
    idle(2);
    check("pre_clr_frames", cnt_frames, 1);
    model_accept(7'b1011010);
    send_bits(7'b1011010, 7, 0);
    clear_cnt = 1'b1;
    idle(1);
    clear_cnt = 1'b0;
    check("clr_win_frames", cnt_frames, 0);
    check("clr_win_corr", cnt_corrected, 0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
